aes_encrypt_ctrl: RTL and testbench

- Block-level sequencer that sits directly upstream and downstream of the single-round AES-128 engine.
- Accepts one plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey.
- Drives the round engine through rounds 0..9, one enable pulse per round, forwarding state and round key between rounds.
- Returns the ciphertext over a valid/ready handshake, and flags an error if the engine stalls.

---
 rtl/aes_encrypt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aes_encrypt_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_ctrl.sv
`timescale 1ns/1ps
// aes_encrypt_ctrl: sequencer around a single-round AES-128 engine.
// Accepts one plaintext/key pair, applies the initial AddRoundKey, issues
// NUM_ROUNDS round-engine starts (forwarding state and round key between
// rounds), then returns the ciphertext. A round that never completes within
// DONE_TIMEOUT cycles aborts the block and raises the sticky err flag.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid/in_ready            input handshake; in_text/in_key (128b each)
//   rnd_enable                   one-cycle start pulse to the round engine
//   rnd_text/rnd_key/rnd_round   engine operands, held stable while waiting
//   rnd_text_out/rnd_key_out     engine results, valid in the cycle after done
//   rnd_done                     engine completion pulse
//   out_valid/out_ready          output handshake; out_text ciphertext
//   err                          sticky timeout flag, cleared on next accept
module aes_encrypt_ctrl #(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         rnd_enable,
  output logic [127:0] rnd_text,
  output logic [127:0] rnd_key,
  output logic [3:0]   rnd_round,
  input  logic [127:0] rnd_text_out,
  input  logic [127:0] rnd_key_out,
  input  logic         rnd_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         err
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned CNT_W  = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_d;
  logic                rnd_enable_d;
  logic [DATA_W-1:0]   rnd_text_d;
  logic [DATA_W-1:0]   rnd_key_d;
  logic [RND_W-1:0]    rnd_round_d;
  logic                out_valid_d;
  logic [DATA_W-1:0]   out_text_d;
  logic                err_d;

  // State and all outputs are registered; reset discards any block in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready   <= 1'b1;
      rnd_enable <= 1'b0;
      rnd_text   <= '0;
      rnd_key    <= '0;
      rnd_round  <= '0;
      out_valid  <= 1'b0;
      out_text   <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready   <= in_ready_d;
      rnd_enable <= rnd_enable_d;
      rnd_text   <= rnd_text_d;
      rnd_key    <= rnd_key_d;
      rnd_round  <= rnd_round_d;
      out_valid  <= out_valid_d;
      out_text   <= out_text_d;
      err        <= err_d;
    end
  end

  // Next-state and next-output logic. rnd_enable is raised on every
  // transition into S_START so the pulse lines up with that state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready_d   = in_ready;
    rnd_enable_d = 1'b0;
    rnd_text_d   = rnd_text;
    rnd_key_d    = rnd_key;
    rnd_round_d  = rnd_round;
    out_valid_d  = out_valid;
    out_text_d   = out_text;
    err_d        = err;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          rnd_text_d   = in_text ^ in_key;
          rnd_key_d    = in_key;
          rnd_round_d  = '0;
          err_d        = 1'b0;
          in_ready_d   = 1'b0;
          rnd_enable_d = 1'b1;
          state_d      = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      // Operands stay frozen here; only the timeout counter moves.
      S_WAIT: begin
        if (rnd_done) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Engine result was registered on the done edge and is valid now.
      S_CAPTURE: begin
        rnd_text_d = rnd_text_out;
        rnd_key_d  = rnd_key_out;
        if (rnd_round == RND_W'(NUM_ROUNDS - 1)) begin
          out_text_d  = rnd_text_out;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          rnd_round_d  = rnd_round + RND_W'(1);
          rnd_enable_d = 1'b1;
          state_d      = S_START;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
`timescale 1ns/1ps
// Testbench for aes_encrypt_ctrl: behavioural AES round engine with a
// configurable done delay, table-driven vectors plus hand-written corner
// sequences, and a scoreboard of expected ciphertexts.
module tb_aes_encrypt_ctrl;

  localparam int NR = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         rnd_enable;
  logic [127:0] rnd_text;
  logic [127:0] rnd_key;
  logic [3:0]   rnd_round;
  logic [127:0] rnd_text_out;
  logic [127:0] rnd_key_out;
  logic         rnd_done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         err;

  aes_encrypt_ctrl #(.NUM_ROUNDS(10), .DONE_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
    .rnd_enable(rnd_enable), .rnd_text(rnd_text), .rnd_key(rnd_key), .rnd_round(rnd_round),
    .rnd_text_out(rnd_text_out), .rnd_key_out(rnd_key_out), .rnd_done(rnd_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- AES reference model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [7:0] rc;
    logic [31:0] t;
    logic [127:0] nk;
    case (r)
      4'd0: rc = 8'h01; 4'd1: rc = 8'h02; 4'd2: rc = 8'h04; 4'd3: rc = 8'h08;
      4'd4: rc = 8'h10; 4'd5: rc = 8'h20; 4'd6: rc = 8'h40; 4'd7: rc = 8'h80;
      4'd8: rc = 8'h1b; 4'd9: rc = 8'h36; default: rc = 8'h00;
    endcase
    t = {sbox[k[103:96]], sbox[k[127:120]], sbox[k[119:112]], sbox[k[111:104]] ^ rc};
    nk[31:0]   = k[31:0]   ^ t;
    nk[63:32]  = k[63:32]  ^ nk[31:0];
    nk[95:64]  = k[95:64]  ^ nk[63:32];
    nk[127:96] = k[127:96] ^ nk[95:64];
    return nk;
  endfunction

  function automatic logic [127:0] round_state(input logic [127:0] s, input logic [127:0] rk,
                                               input logic [3:0] r);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = b[rw + 4*((c + rw) % 4)];
    if (r != 4'(NR - 1)) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ rk[8*i +: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k, nk;
    s = pt ^ key; k = key;
    for (int r = 0; r < NR; r++) begin
      nk = next_key(k, 4'(r));
      s  = round_state(s, nk, 4'(r));
      k  = nk;
    end
    return s;
  endfunction

  // ---------------- round engine model ----------------
  // Done is asserted eng_d+1 cycles after the enable cycle; results are
  // registered on the done edge. eng_hang suppresses done entirely.
  int           eng_d = 1;
  bit           eng_hang = 1'b0;
  bit           spur_done = 1'b0;
  int           eng_cnt;
  logic [127:0] eng_rt, eng_rk;

  assign rnd_done = ((eng_cnt == 1) && !eng_hang) || spur_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_cnt      <= 0;
      rnd_text_out <= '0;
      rnd_key_out  <= '0;
    end else if (rnd_enable) begin
      eng_cnt <= eng_d + 1;
      eng_rt  <= round_state(rnd_text, next_key(rnd_key, rnd_round), rnd_round);
      eng_rk  <= next_key(rnd_key, rnd_round);
    end else if (eng_cnt > 0) begin
      if (eng_cnt == 1 && !eng_hang) begin
        rnd_text_out <= eng_rt;
        rnd_key_out  <= eng_rk;
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  logic [127:0] sb [$];
  logic [127:0] cur_exp;
  logic [127:0] hold_text, hold_key, prev_out;
  logic [3:0]   hold_round;
  int exp_round, en_count, acc_cyc, hs_cyc, exp_lat, ov_total, accepts;
  bit prev_en, prev_ov, ov_seen;

  task automatic monitor();
    logic [127:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        sb.delete();
        prev_en = 1'b0; prev_ov = 1'b0; ov_seen = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          sb.push_back(cur_exp);
          acc_cyc = cyc; exp_round = 0; en_count = 0; ov_seen = 1'b0; accepts++;
        end
        if (rnd_enable) begin
          check_eq("enable_one_cycle", 128'(prev_en), 128'(0));
          check_eq("round_seq", 128'(rnd_round), 128'(exp_round));
          hold_text = rnd_text; hold_key = rnd_key; hold_round = rnd_round;
          exp_round++; en_count++;
        end else if (eng_cnt > 0) begin
          check_eq("wait_text_stable", rnd_text, hold_text);
          check_eq("wait_key_stable", rnd_key, hold_key);
          check_eq("wait_round_stable", 128'(rnd_round), 128'(hold_round));
        end
        if (out_valid) begin
          ov_total++;
          check_eq("in_ready_during_out", 128'(in_ready), 128'(0));
          if (!ov_seen) begin
            ov_seen = 1'b1;
            if (exp_lat > 0) check_eq("latency", 128'(cyc - acc_cyc), 128'(exp_lat));
          end else if (prev_ov) begin
            check_eq("out_text_stable", out_text, prev_out);
          end
          if (out_ready) begin
            check_eq("enable_count", 128'(en_count), 128'(NR));
            check_eq("sb_pending", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check_eq("ciphertext", out_text, e);
            end
            hs_cyc = cyc; ov_seen = 1'b0;
          end
        end
        prev_en  = rnd_enable;
        prev_ov  = out_valid && !out_ready;
        prev_out = out_text;
      end
    end
  endtask

  // kind: 0 in_ready, 1 out_valid, 2 output handshake, 3 err, 4 round 5 issued
  task automatic wait_until(input int kind, input int bound, input string name);
    int n;
    bit hit;
    n = 0; hit = 1'b0;
    while (n < bound && !hit) begin
      @(negedge clock);
      n++;
      case (kind)
        0: hit = in_ready;
        1: hit = out_valid;
        2: hit = out_valid && out_ready;
        3: hit = err;
        default: hit = (exp_round >= 6);
      endcase
    end
    check_eq(name, 128'(hit), 128'(1));
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"},   128'(in_ready),   128'(1));
    check_eq({tag, "_out_valid"},  128'(out_valid),  128'(0));
    check_eq({tag, "_err"},        128'(err),        128'(0));
    check_eq({tag, "_rnd_enable"}, 128'(rnd_enable), 128'(0));
    check_eq({tag, "_rnd_round"},  128'(rnd_round),  128'(0));
    check_eq({tag, "_rnd_text"},   rnd_text, 128'(0));
    check_eq({tag, "_rnd_key"},    rnd_key,  128'(0));
    check_eq({tag, "_out_text"},   out_text, 128'(0));
  endtask

  typedef struct {
    logic [127:0] text;
    logic [127:0] key;
    logic [127:0] exp;
    int           d;
    int           stall;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v, input bit chk_err);
    @(posedge clock); #1;
    eng_d = v.d; exp_lat = 1 + NR * (3 + v.d); cur_exp = v.exp;
    in_text = v.text; in_key = v.key; in_valid = 1'b1; out_ready = (v.stall == 0);
    wait_until(0, 100, "wait_accept");
    @(posedge clock); #1;
    in_valid = 1'b0; in_text = ~v.text; in_key = ~v.key;
    if (chk_err) check_eq("err_cleared_on_accept", 128'(err), 128'(0));
    if (v.stall > 0) begin
      wait_until(1, 400, "wait_out_valid");
      repeat (v.stall) @(negedge clock);
      @(posedge clock); #1 out_ready = 1'b1;
    end
    wait_until(2, 400, "wait_handshake");
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] r0, r1;
    int tacc, ovb, accb;
    reset = 1'b1; in_valid = 1'b0; in_text = '0; in_key = '0; out_ready = 1'b1;
    exp_round = 0; en_count = 0; acc_cyc = 0; hs_cyc = 0; exp_lat = 0;
    ov_total = 0; accepts = 0; cur_exp = '0;
    build_sbox();
    fork monitor(); join_none

    r0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    vecs[0] = '{FIPS_PT, FIPS_KEY, FIPS_CT, 1, 0};
    vecs[1] = '{128'h0, 128'h0, 128'h2e2b34ca59fa4c883b2c8aefd44be966, 7, 0};
    vecs[2] = '{128'h0123456789abcdeffedcba9876543210, 128'hdeadbeefcafef00d0badc0de12345678,
                aes_ref(128'h0123456789abcdeffedcba9876543210,
                        128'hdeadbeefcafef00d0badc0de12345678), 2, 5};
    vecs[3] = '{r0, r1, aes_ref(r0, r1), 3, 1};

    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    @(posedge clock); #1 reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

    // Backpressure with in_valid held high, plus a spurious done in OUT.
    @(posedge clock); #1;
    eng_d = 1; exp_lat = 41; cur_exp = FIPS_CT;
    in_text = FIPS_PT; in_key = FIPS_KEY; in_valid = 1'b1; out_ready = 1'b0;
    wait_until(0, 100, "bp_accept");
    wait_until(1, 200, "bp_out_valid");
    accb = accepts;
    repeat (10) @(negedge clock);
    @(posedge clock); #1 spur_done = 1'b1;
    @(posedge clock); #1 spur_done = 1'b0;
    @(negedge clock);
    check_eq("spur_out_valid", 128'(out_valid), 128'(1));
    check_eq("spur_out_text", out_text, FIPS_CT);
    check_eq("spur_out_round", 128'(rnd_round), 128'(9));
    repeat (8) @(negedge clock);
    check_eq("bp_no_accept", 128'(accepts), 128'(accb));
    @(posedge clock); #1 out_ready = 1'b1;
    wait_until(2, 20, "bp_handshake");
    wait_until(0, 20, "bp_second_accept");
    check_eq("bp_accept_after_hs", 128'(acc_cyc), 128'(hs_cyc + 1));
    @(posedge clock); #1 in_valid = 1'b0;
    wait_until(2, 200, "bp_second_handshake");

    // Spurious done while idle.
    @(posedge clock); #1 spur_done = 1'b1;
    @(posedge clock); #1 spur_done = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("idle_spur_in_ready", 128'(in_ready), 128'(1));
    check_eq("idle_spur_out_valid", 128'(out_valid), 128'(0));
    check_eq("idle_spur_enable", 128'(rnd_enable), 128'(0));
    check_eq("idle_spur_round", 128'(rnd_round), 128'(9));
    check_eq("idle_spur_rnd_text", rnd_text, FIPS_CT);
    check_eq("idle_spur_out_text", out_text, FIPS_CT);

    // Engine never completes: timeout path.
    @(posedge clock); #1;
    eng_hang = 1'b1; eng_d = 1; exp_lat = 0; cur_exp = vecs[2].exp;
    in_text = vecs[2].text; in_key = vecs[2].key; in_valid = 1'b1; out_ready = 1'b1;
    wait_until(0, 100, "to_accept");
    tacc = acc_cyc; ovb = ov_total;
    @(posedge clock); #1 in_valid = 1'b0;
    wait_until(3, 200, "to_err");
    check_eq("to_err_cycle", 128'(cyc - tacc), 128'(66));
    check_eq("to_in_ready", 128'(in_ready), 128'(1));
    check_eq("to_out_valid", 128'(out_valid), 128'(0));
    repeat (5) @(negedge clock);
    check_eq("to_no_output", 128'(ov_total), 128'(ovb));
    check_eq("to_err_sticky", 128'(err), 128'(1));
    sb.delete();
    eng_hang = 1'b0;
    run_vec(vecs[2], 1'b1);
    check_eq("to_err_after_block", 128'(err), 128'(0));

    // Asynchronous reset in the WAIT of round 5.
    @(posedge clock); #1;
    eng_d = 7; exp_lat = 101; cur_exp = FIPS_CT;
    in_text = FIPS_PT; in_key = FIPS_KEY; in_valid = 1'b1; out_ready = 1'b1;
    wait_until(0, 100, "rst_accept");
    @(posedge clock); #1 in_valid = 1'b0;
    wait_until(4, 600, "rst_reach_round5");
    @(negedge clock); #2;
    check_eq("rst_round_before", 128'(rnd_round), 128'(5));
    reset = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    run_vec(vecs[0], 1'b0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
